wb_trace_fifo: RTL
==================

// Module: wb_trace_fifo
// PURPOSE
//  Downstream consumer of the processor's writeback stage: captures every WB
//  event (destination register + value) into a show-ahead FIFO. A debug host
//  drains the FIFO through a valid/ready port.
//  Sits beside the WB stage, fed by WB_Enable_out / DR_out / WB_val_out.
//  Retirement order is preserved. Overflow is counted, never silent.
// PARAMETERS
//  DEPTH   16  number of FIFO entries; power of two, >= 2
//  AW      4   pointer width; log2(DEPTH)
//  SEQ_W   8   width of the per-event sequence tag
// PORTS
//  CLOCK_50     in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  wb_en        in   1      WB stage writes a register this cycle
//  wb_dr        in   3      WB destination register
//  wb_val       in   16     WB value
//  freeze       in   1      1 = stop capturing; draining continues
//  trace_ready  in   1      host accepts the head entry
//  trace_valid  out  1      head entry available (FIFO not empty)
//  trace_seq    out  SEQ_W  head entry sequence tag
//  trace_dr     out  3      head entry destination register
//  trace_val    out  16     head entry value
//  trace_ts     out  16     head entry cycle timestamp (see CONFIGURATION)
//  fifo_count   out  AW+1   entries held, 0..DEPTH
//  drop_cnt     out  8      events lost to a full FIFO; saturates at 255
// BEHAVIOUR
//  - Reset (any time, including mid-drain) clears wr_ptr, rd_ptr, fifo_count,
//    seq counter, drop_cnt and the timestamp counter to 0. Stored entries are lost.
//    After reset, trace_valid=0 and all trace_* data outputs read 0.
//  - Event: wb_en=1 && freeze=0 at a rising edge.
//    Each event consumes the current seq value, then seq <= seq+1 (mod 2^SEQ_W).
//  - Push: an event with the FIFO not full, or full but popping in the same cycle.
//    It writes {seq,wb_dr,wb_val,ts} at wr_ptr, and wr_ptr <= wr_ptr+1 (wraps mod DEPTH).
//  - Drop: an event with fifo_count==DEPTH and no pop in the same cycle.
//    No write occurs. drop_cnt increments and saturates at 8'hFF.
//    seq still advances, so the host sees a gap in the tags.
//  - Pop: trace_valid && trace_ready at the edge. rd_ptr <= rd_ptr+1 (wraps).
//  - fifo_count: +1 on push only, -1 on pop only, unchanged on push+pop.
//  - Show-ahead: trace_* are driven combinationally from mem[rd_ptr], and
//    trace_valid = (fifo_count != 0).
//    Latency: an event at edge N is visible on the outputs after edge N.
//  - Push+pop while empty: the pop is ignored (trace_valid=0). The push is taken.
//  - trace_ready while empty has no effect.
//  - trace_* are held stable while trace_valid=1 and trace_ready=0.
//  - freeze=1: events are ignored completely (seq does not advance, drop_cnt unchanged).
//    Pops continue normally.
//  - No state machine beyond the pointer/counter set. Full and empty are derived
//    from fifo_count, not from pointer equality.
// CONFIGURATION
//  - Macro WB_TRACE_TIMESTAMP_EN defined:
//    A free-running 16-bit cycle counter ts increments every clock and wraps
//    at 16'hFFFF->0. It is stored with each entry; trace_ts = the head entry's ts.
//  - Macro undefined:
//    No counter and no ts storage. trace_ts is tied to 16'h0000.
// TESTING
//  1. Reset, then wb_en pulses with (dr=1,val=16'h1234) and (dr=2,val=16'hABCD),
//     trace_ready=0.
//     -> fifo_count=2, trace_valid=1, head = seq 0 / dr 1 / val 16'h1234.
//  2. Continuing from 1, raise trace_ready for 2 cycles.
//     -> pops seq0, then seq1 (dr 2, 16'hABCD). Then trace_valid=0, fifo_count=0.
//  3. 20 consecutive events (val=i), trace_ready=0.
//     -> fifo_count=16, drop_cnt=4. Draining yields seq 0..15; the next event gets seq 20.
//  4. FIFO full, then wb_en and trace_ready both 1 in the same cycle.
//     -> fifo_count stays 16, drop_cnt unchanged, new entry stored at tail.
//  5. freeze=1 with 3 events, then freeze=0 with 1 event.
//     -> only 1 entry, seq 0, drop_cnt 0.
//  6. Assert reset with 5 entries held.
//     -> asynchronously trace_valid=0, fifo_count=0, drop_cnt=0.
//     With WB_TRACE_TIMESTAMP_EN, the first post-reset event at cycle 3 has trace_ts=3.

Source files
------------

// File: rtl/wb_trace_fifo_if.sv
// Writeback trace port bundle: WB capture inputs plus the host drain port.
interface wb_trace_fifo_if #(
  parameter int unsigned AW    = 4,
  parameter int unsigned SEQ_W = 8
) ();
  logic             wb_en;
  logic [2:0]       wb_dr;
  logic [15:0]      wb_val;
  logic             freeze;
  logic             trace_ready;
  logic             trace_valid;
  logic [SEQ_W-1:0] trace_seq;
  logic [2:0]       trace_dr;
  logic [15:0]      trace_val;
  logic [15:0]      trace_ts;
  logic [AW:0]      fifo_count;
  logic [7:0]       drop_cnt;

  // Producer/host side: drives WB events and the drain handshake
  modport master (
    output wb_en, wb_dr, wb_val, freeze, trace_ready,
    input  trace_valid, trace_seq, trace_dr, trace_val, trace_ts,
           fifo_count, drop_cnt
  );

  // FIFO side
  modport slave (
    input  wb_en, wb_dr, wb_val, freeze, trace_ready,
    output trace_valid, trace_seq, trace_dr, trace_val, trace_ts,
           fifo_count, drop_cnt
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures WB events {seq, dr, val[, ts]} into a
// show-ahead FIFO drained by a debug host over valid/ready. Full-FIFO events
// are dropped and counted (saturating), with the sequence tag still advancing.
// Optional feature: define WB_TRACE_TIMESTAMP_EN to store a 16-bit cycle
// timestamp with each entry; otherwise trace_ts is tied to zero.
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  wb_trace_fifo_if.slave bus
);

  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [2:0]       dr;
    logic [15:0]      val;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [SEQ_W-1:0] seq;
  logic [7:0]       drop_cnt;

  logic event_c;
  logic full_c;
  logic valid_c;
  logic pop_c;
  logic push_c;
  logic drop_c;
  entry_t head_c;

  // Handshake decode; full/empty come from the occupancy counter
  always_comb begin
    event_c = bus.wb_en & ~bus.freeze;
    full_c  = (count == CW'(DEPTH));
    valid_c = (count != '0);
    pop_c   = valid_c & bus.trace_ready;
    push_c  = event_c & (~full_c | pop_c);
    drop_c  = event_c & full_c & ~pop_c;
    head_c  = mem[rd_ptr];
  end

  // Entry storage; contents need no reset since outputs are gated by valid
  always_ff @(posedge CLOCK_50) begin
    if (push_c) begin
      mem[wr_ptr] <= '{seq: seq, dr: bus.wb_dr, val: bus.wb_val};
    end
  end

  // Pointers, occupancy, sequence tag and drop counter
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (pop_c && !push_c) count <= count - CW'(1);
      if (event_c) seq <= seq + SEQ_W'(1);
      if (drop_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [15:0] ts;
  logic [15:0] ts_mem [DEPTH];

  // Free-running cycle counter, wraps naturally at 16 bits
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 16'd1;
  end

  // Timestamp storage alongside each entry
  always_ff @(posedge CLOCK_50) begin
    if (push_c) ts_mem[wr_ptr] <= ts;
  end

  assign bus.trace_ts = valid_c ? ts_mem[rd_ptr] : 16'h0000;
`else
  assign bus.trace_ts = 16'h0000;
`endif

  // Show-ahead head entry, forced to zero while empty
  assign bus.trace_valid = valid_c;
  assign bus.trace_seq   = valid_c ? head_c.seq : '0;
  assign bus.trace_dr    = valid_c ? head_c.dr  : 3'd0;
  assign bus.trace_val   = valid_c ? head_c.val : 16'h0000;
  assign bus.fifo_count  = count;
  assign bus.drop_cnt    = drop_cnt;

endmodule
